// File: rtl/age_arb_pipe.sv
// Pipelined oldest-first arbiter. A binary tree of 2-input age comparators
// picks the oldest valid request, with one register stage per tree level.
// Equal timestamps are resolved by a rotating round-robin pointer. The whole
// pipeline stalls while the output holds an unaccepted winner.
module age_arb_pipe #(
  parameter int N_IN       = 8,
  parameter int TIME_WIDTH = 8,
  parameter int IDX_W      = 3,
  parameter int WRAP_CMP   = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_IN-1:0]            in_valid,
  input  logic [N_IN*TIME_WIDTH-1:0] in_time,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [TIME_WIDTH-1:0]      out_time,
  output logic [IDX_W-1:0]           out_index,
  output logic [N_IN-1:0]            out_grant,
  input  logic                       out_ready
);

  localparam int LVL = $clog2(N_IN);

  // Stage l holds the winners of tree level l+1; only the low N_IN>>(l+1)
  // entries of each stage carry meaning, the rest simply sit at zero.
  logic                  valid_q [LVL][N_IN];
  logic                  valid_d [LVL][N_IN];
  logic [TIME_WIDTH-1:0] time_q  [LVL][N_IN];
  logic [TIME_WIDTH-1:0] time_d  [LVL][N_IN];
  logic [IDX_W-1:0]      idx_q   [LVL][N_IN];
  logic [IDX_W-1:0]      idx_d   [LVL][N_IN];
  logic [IDX_W-1:0]      rkey_q  [LVL][N_IN];
  logic [IDX_W-1:0]      rkey_d  [LVL][N_IN];
  logic [IDX_W-1:0]      rr_ptr_q;
  logic [IDX_W-1:0]      rr_ptr_d;

  logic                  advance;
  logic                  a_v, b_v, a_win;
  logic [TIME_WIDTH-1:0] a_t, b_t;
  logic [IDX_W-1:0]      a_i, b_i, a_k, b_k;

  // The oldest valid side wins; equal times go to the smaller rotated key.
  function automatic logic a_wins(
    input logic                  av,
    input logic [TIME_WIDTH-1:0] at,
    input logic [IDX_W-1:0]      ak,
    input logic                  bv,
    input logic [TIME_WIDTH-1:0] bt,
    input logic [IDX_W-1:0]      bk
  );
    logic [TIME_WIDTH-1:0] diff;
    logic                  older;
    diff = at - bt;
    if (WRAP_CMP != 0) older = (at != bt) & diff[TIME_WIDTH-1];
    else               older = (at < bt);
    return av & (!bv | older | ((at == bt) & (ak < bk)));
  endfunction

  assign out_valid = valid_q[LVL-1][0];
  assign out_time  = time_q[LVL-1][0];
  assign out_index = idx_q[LVL-1][0];
  assign advance   = !out_valid | out_ready;
  assign in_ready  = advance;

  // Grant is the one-hot form of the registered winner index.
  always_comb begin
    out_grant = '0;
    if (out_valid) out_grant[out_index] = 1'b1;
  end

  // Round-robin pointer moves past the winner only when it is accepted.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (out_valid & out_ready) rr_ptr_d = out_index + IDX_W'(1);
  end

  // Comparator tree: every stage holds on stall, otherwise each node takes
  // the winner of its two children (ports for level 1, previous stage above).
  always_comb begin
    a_v = 1'b0; b_v = 1'b0; a_win = 1'b0;
    a_t = '0;   b_t = '0;
    a_i = '0;   b_i = '0;   a_k = '0; b_k = '0;
    for (int l = 0; l < LVL; l++) begin
      for (int n = 0; n < N_IN; n++) begin
        valid_d[l][n] = valid_q[l][n];
        time_d[l][n]  = time_q[l][n];
        idx_d[l][n]   = idx_q[l][n];
        rkey_d[l][n]  = rkey_q[l][n];
      end
    end
    if (advance) begin
      for (int l = 0; l < LVL; l++) begin
        for (int n = 0; n < N_IN; n++) begin
          if (n < (N_IN >> (l + 1))) begin
            if (l == 0) begin
              a_v = in_valid[2*n];
              a_t = in_time[(2*n)*TIME_WIDTH +: TIME_WIDTH];
              a_i = IDX_W'(2*n);
              a_k = IDX_W'(2*n) - rr_ptr_q;
              b_v = in_valid[2*n+1];
              b_t = in_time[(2*n+1)*TIME_WIDTH +: TIME_WIDTH];
              b_i = IDX_W'(2*n+1);
              b_k = IDX_W'(2*n+1) - rr_ptr_q;
            end else begin
              a_v = valid_q[l-1][2*n];
              a_t = time_q[l-1][2*n];
              a_i = idx_q[l-1][2*n];
              a_k = rkey_q[l-1][2*n];
              b_v = valid_q[l-1][2*n+1];
              b_t = time_q[l-1][2*n+1];
              b_i = idx_q[l-1][2*n+1];
              b_k = rkey_q[l-1][2*n+1];
            end
            a_win         = a_wins(a_v, a_t, a_k, b_v, b_t, b_k);
            valid_d[l][n] = a_v | b_v;
            time_d[l][n]  = a_win ? a_t : b_t;
            idx_d[l][n]   = a_win ? a_i : b_i;
            rkey_d[l][n]  = a_win ? a_k : b_k;
          end
        end
      end
    end
  end

  // Pipeline and pointer registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int l = 0; l < LVL; l++) begin
        for (int n = 0; n < N_IN; n++) begin
          valid_q[l][n] <= 1'b0;
          time_q[l][n]  <= '0;
          idx_q[l][n]   <= '0;
          rkey_q[l][n]  <= '0;
        end
      end
      rr_ptr_q <= '0;
    end else begin
      for (int l = 0; l < LVL; l++) begin
        for (int n = 0; n < N_IN; n++) begin
          valid_q[l][n] <= valid_d[l][n];
          time_q[l][n]  <= time_d[l][n];
          idx_q[l][n]   <= idx_d[l][n];
          rkey_q[l][n]  <= rkey_d[l][n];
        end
      end
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule
